// File: rtl/enet_tx_mac.sv
// 10BASE-T transmit MAC sequencer: frames host bytes into preamble/SFD/payload/pad/FCS
// and serialises them at two clocks per bit onto the PLS interface, then enforces the IFG.
//
//  state    | meaning
//  ---------+--------------------------------------------------------------
//  IDLE     | gap satisfied, waiting for a host byte with PLS not busy
//  PREAMBLE | 7 x 0x55 then SFD 0xD5, CRC frozen
//  DATA     | host bytes from the holding register, CRC running
//  PAD      | zero bytes up to MIN_PAYLOAD, CRC running
//  FCS      | inverted CRC, 32 bits LSB first
//  IFG      | interframe gap countdown, then wait for PLS idle
module enet_tx_mac #(
    parameter int IFG_CYCLES  = 192,
    parameter int MIN_PAYLOAD = 60
) (
    input  logic       clk_20mhz,
    input  logic       rst_i,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    input  logic       tx_last,
    output logic       tx_ready,
    input  logic       txbusy,
    output logic       data_enable,
    output logic       txd_out,
    output logic       frame_done,
    output logic       tx_underrun
);

    typedef enum logic [2:0] {IDLE, PREAMBLE, DATA, PAD, FCS, IFG} state_t;

    localparam logic [31:0] CRC_POLY = 32'hEDB88320;
    localparam logic [10:0] MIN_CNT  = 11'(MIN_PAYLOAD);
    localparam logic [15:0] IFG_LOAD = 16'(IFG_CYCLES);

    state_t      state;
    logic        ready_en;
    logic [7:0]  hold_data;
    logic        hold_last;
    logic        hold_full;
    logic        last_taken;
    logic        cur_last;
    logic [31:0] shreg;
    logic [4:0]  bit_cnt;
    logic        phase;
    logic [2:0]  pre_cnt;
    logic [10:0] byte_cnt;
    logic [31:0] crc;
    logic [15:0] ifg_cnt;

    logic [31:0] crc_next;
    logic [31:0] fcs_word;
    logic [4:0]  bit_last;
    logic [10:0] byte_inc;
    logic        accept;

    assign crc_next = {1'b0, crc[31:1]} ^ ((crc[0] ^ txd_out) ? CRC_POLY : 32'd0);
    assign fcs_word = ~crc;
    assign bit_last = (state == FCS) ? 5'd31 : 5'd7;
    assign byte_inc = (byte_cnt == 11'h7FF) ? byte_cnt : byte_cnt + 11'd1;

    // ready_en delays tx_ready by one cycle after reset release
    assign tx_ready = ready_en & ~hold_full & ~last_taken & (state != IFG);
    assign accept   = tx_valid & tx_ready;

    always_ff @(posedge clk_20mhz) begin
        if (rst_i) begin
            state       <= IDLE;
            ready_en    <= 1'b0;
            hold_data   <= '0;
            hold_last   <= 1'b0;
            hold_full   <= 1'b0;
            last_taken  <= 1'b0;
            cur_last    <= 1'b0;
            shreg       <= '0;
            bit_cnt     <= '0;
            phase       <= 1'b0;
            pre_cnt     <= '0;
            byte_cnt    <= '0;
            crc         <= '1;
            ifg_cnt     <= '0;
            data_enable <= 1'b0;
            txd_out     <= 1'b0;
            frame_done  <= 1'b0;
            tx_underrun <= 1'b0;
        end else begin
            ready_en    <= 1'b1;
            frame_done  <= 1'b0;
            tx_underrun <= 1'b0;
            case (state)
                IDLE: begin
                    if ((accept | hold_full) & ~txbusy) begin
                        state       <= PREAMBLE;
                        data_enable <= 1'b1;
                        shreg       <= 32'h0000_0055;
                        txd_out     <= 1'b1;
                        bit_cnt     <= '0;
                        phase       <= 1'b0;
                        pre_cnt     <= '0;
                        byte_cnt    <= '0;
                        crc         <= '1;
                    end
                end
                IFG: begin
                    if (ifg_cnt != 16'd0) begin
                        ifg_cnt <= ifg_cnt - 16'd1;
                    end else if (!txbusy) begin
                        state      <= IDLE;
                        last_taken <= 1'b0;
                    end
                end
                default: begin
                    if (!phase) begin
                        phase <= 1'b1;
                        if (state == DATA || state == PAD) crc <= crc_next;
                    end else begin
                        phase <= 1'b0;
                        if (bit_cnt != bit_last) begin
                            bit_cnt <= bit_cnt + 5'd1;
                            shreg   <= {1'b0, shreg[31:1]};
                            txd_out <= shreg[1];
                        end else begin
                            bit_cnt <= '0;
                            // byte (or FCS word) slot boundary: pick the next thing to send
                            if (state == PREAMBLE && pre_cnt != 3'd7) begin
                                pre_cnt <= pre_cnt + 3'd1;
                                shreg   <= (pre_cnt == 3'd6) ? 32'h0000_00D5 : 32'h0000_0055;
                                txd_out <= 1'b1;
                            end else if (state == FCS) begin
                                frame_done  <= 1'b1;
                                data_enable <= 1'b0;
                                txd_out     <= 1'b0;
                                state       <= IFG;
                                ifg_cnt     <= IFG_LOAD;
                            end else if ((state == DATA && cur_last) || state == PAD) begin
                                if (byte_cnt < MIN_CNT) begin
                                    state    <= PAD;
                                    shreg    <= '0;
                                    txd_out  <= 1'b0;
                                    byte_cnt <= byte_inc;
                                end else begin
                                    state   <= FCS;
                                    shreg   <= fcs_word;
                                    txd_out <= fcs_word[0];
                                end
                            end else if (hold_full) begin
                                state     <= DATA;
                                shreg     <= {24'd0, hold_data};
                                txd_out   <= hold_data[0];
                                cur_last  <= hold_last;
                                hold_full <= 1'b0;
                                byte_cnt  <= byte_inc;
                            end else begin
                                tx_underrun <= 1'b1;
                                data_enable <= 1'b0;
                                txd_out     <= 1'b0;
                                state       <= IFG;
                                ifg_cnt     <= IFG_LOAD;
                            end
                        end
                    end
                end
            endcase
            if (accept) begin
                hold_data <= tx_data;
                hold_last <= tx_last;
                hold_full <= 1'b1;
                if (tx_last) last_taken <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_enet_tx_mac.sv
// Bench for enet_tx_mac: two instances (no padding / default padding) sharing one host
// driver, a wire-level frame capture, a PLS busy model and a byte-level frame model.
module tb_enet_tx_mac;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_last = 1'b0;
    logic       txbusy = 1'b0;
    logic       sel = 1'b0;

    logic val_a, val_b;
    logic ready_a, de_a, txd_a, fd_a, ur_a;
    logic ready_b, de_b, txd_b, fd_b, ur_b;
    logic ready, de, txd, fd, ur;

    assign val_a = tx_valid & ~sel;
    assign val_b = tx_valid & sel;
    assign ready = sel ? ready_b : ready_a;
    assign de    = sel ? de_b : de_a;
    assign txd   = sel ? txd_b : txd_a;
    assign fd    = sel ? fd_b : fd_a;
    assign ur    = sel ? ur_b : ur_a;

    enet_tx_mac #(.IFG_CYCLES(192), .MIN_PAYLOAD(0)) u_a (
        .clk_20mhz(clk), .rst_i(rst), .tx_data(tx_data), .tx_valid(val_a),
        .tx_last(tx_last), .tx_ready(ready_a), .txbusy(txbusy),
        .data_enable(de_a), .txd_out(txd_a), .frame_done(fd_a), .tx_underrun(ur_a));

    enet_tx_mac u_b (
        .clk_20mhz(clk), .rst_i(rst), .tx_data(tx_data), .tx_valid(val_b),
        .tx_last(tx_last), .tx_ready(ready_b), .txbusy(txbusy),
        .data_enable(de_b), .txd_out(txd_b), .frame_done(fd_b), .tx_underrun(ur_b));

    always #25 clk = ~clk;

    int tests = 0;
    int fails = 0;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // wire capture, event log and PLS busy model
    bit de_prev = 1'b0;
    int hi = 0;
    int rise_cyc = 0, fall_cyc = 0, fd_cyc = 0, ur_cyc = 0, busy_fall = 0;
    int nframes = 0, fd_cnt = 0, ur_cnt = 0, glitches = 0, flen = 0;
    int busy_cnt = 0, busy_extra = 0;
    bit cur_bits[$];
    bit fbits[$];

    always @(negedge clk) begin
        if (de) begin
            if (!de_prev) begin
                cur_bits.delete();
                hi = 0;
                rise_cyc = cyc;
            end
            if (hi % 2 == 0) cur_bits.push_back(txd);
            else if (txd !== cur_bits[$]) glitches++;
            hi++;
        end else if (de_prev) begin
            fbits = cur_bits;
            flen = hi;
            fall_cyc = cyc;
            nframes++;
        end
        de_prev = de;
        if (fd) begin fd_cnt++; fd_cyc = cyc; end
        if (ur) begin ur_cnt++; ur_cyc = cyc; end
        if (de) begin
            txbusy = 1'b1;
            busy_cnt = 60 + busy_extra;
        end else if (busy_cnt > 0) begin
            busy_cnt--;
            if (busy_cnt == 0) begin
                txbusy = 1'b0;
                busy_fall = cyc;
            end
        end
    end

    // reference model: frame as a byte list, CRC computed per byte in plain arithmetic
    logic [7:0] payload[$];
    logic [7:0] p1[$];
    logic [7:0] p2[$];
    bit exp_bits[$];

    function automatic logic [31:0] crc_byte(input logic [31:0] c_in, input logic [7:0] d);
        logic [31:0] c = c_in;
        for (int k = 0; k < 8; k++) begin
            if ((c[0] ^ d[k]) == 1'b1) c = (c >> 1) ^ 32'hEDB88320;
            else c = c >> 1;
        end
        return c;
    endfunction

    function automatic void build_exp(input int minp, input bit with_fcs);
        logic [7:0] bytes[$];
        logic [31:0] c = 32'hFFFF_FFFF;
        logic [31:0] f;
        logic [7:0] b;
        int n;
        exp_bits.delete();
        for (int i = 0; i < 7; i++) bytes.push_back(8'h55);
        bytes.push_back(8'hD5);
        for (int i = 0; i < payload.size(); i++) begin
            bytes.push_back(payload[i]);
            c = crc_byte(c, payload[i]);
        end
        n = payload.size();
        while (n < minp) begin
            bytes.push_back(8'h00);
            c = crc_byte(c, 8'h00);
            n++;
        end
        f = ~c;
        if (with_fcs) for (int j = 0; j < 4; j++) bytes.push_back(f[8*j +: 8]);
        for (int i = 0; i < bytes.size(); i++) begin
            b = bytes[i];
            for (int k = 0; k < 8; k++) exp_bits.push_back(b[k]);
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic chk_range(input string tag, input int obs, input int lo, input int hi_b);
        tests++;
        assert (obs >= lo && obs <= hi_b) else begin
            fails++;
            $error("FAIL %s: observed %0d required %0d..%0d", tag, obs, lo, hi_b);
        end
    endtask

    task automatic check_frame(input string tag, input int minp, input bit with_fcs, input int exp_len);
        int nmis = 0;
        int n;
        build_exp(minp, with_fcs);
        chk({tag, "_nbits"}, fbits.size(), exp_bits.size());
        n = (fbits.size() < exp_bits.size()) ? fbits.size() : exp_bits.size();
        for (int i = 0; i < n; i++) if (fbits[i] !== exp_bits[i]) nmis++;
        chk({tag, "_bit_errors"}, nmis, 0);
        chk({tag, "_de_len"}, flen, exp_len);
    endtask

    task automatic push(input logic [7:0] d, input bit l);
        int n = 0;
        bit ok = 1'b0;
        tx_data = d;
        tx_last = l;
        tx_valid = 1'b1;
        while (!ok && n < 5000) begin
            #1;
            if (ready) ok = 1'b1;
            @(negedge clk);
            n++;
        end
        tx_valid = 1'b0;
        tx_last = 1'b0;
        if (!ok) chk("push_timeout", 0, 1);
    endtask

    task automatic send(input int jit_max, input bit with_last);
        for (int i = 0; i < payload.size(); i++) begin
            repeat ($urandom_range(jit_max, 0)) @(negedge clk);
            push(payload[i], with_last && (i == payload.size() - 1));
        end
    endtask

    task automatic wait_frame(input string tag);
        int prev = nframes;
        int n = 0;
        while (nframes == prev && n < 20000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_frame_ended"}, (nframes != prev) ? 1 : 0, 1);
    endtask

    task automatic fill(input int n);
        payload.delete();
        for (int i = 0; i < n; i++) payload.push_back(8'($urandom));
    endtask

    function automatic int padded_len(input int n);
        return 16 * (12 + ((n > 60) ? n : 60));
    endfunction

    task automatic back_to_back(input string tag, input int extra);
        busy_extra = extra;
        fill(5);  p1 = payload; send(0, 1);
        fill(3);  p2 = payload; send(0, 1);
        repeat (2) @(negedge clk);
        payload = p1;
        check_frame({tag, "_f1"}, 60, 1, padded_len(5));
        chk_range({tag, "_gap_after_done"}, rise_cyc - fd_cyc, 193, (extra == 0) ? 194 : 100000);
        if (extra != 0) chk_range({tag, "_start_after_busy"}, rise_cyc - busy_fall, 1, 2);
        payload = p2;
        wait_frame({tag, "_f2"});
        check_frame({tag, "_f2"}, 60, 1, padded_len(3));
        busy_extra = 0;
    endtask

    int f0, u0;
    logic [31:0] fcs_obs;
    int lens[3] = '{59, 60, 61};

    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_de_a", de_a, 0);
        chk("rst_de_b", de_b, 0);
        chk("rst_txd_a", txd_a, 0);
        chk("rst_ready_b", ready_b, 0);
        chk("rst_frame_done_b", fd_b, 0);
        chk("rst_underrun_a", ur_a, 0);
        rst = 1'b0;
        #1 chk("ready_at_release", ready_a, 0);
        @(negedge clk);
        chk("ready_after_release_a", ready_a, 1);
        chk("ready_after_release_b", ready_b, 1);

        // CRC check on the unpadded instance
        sel = 1'b0;
        payload = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        f0 = fd_cnt;
        send(0, 1);
        wait_frame("crc");
        check_frame("crc", 0, 1, 336);
        chk("crc_frame_done_count", fd_cnt - f0, 1);
        fcs_obs = '0;
        for (int j = 0; j < 32; j++) if (136 + j < fbits.size()) fcs_obs[j] = fbits[136 + j];
        chk("crc_fcs_word", fcs_obs, 32'hCBF43926);

        // underrun: three bytes, no tx_last
        fill(3);
        f0 = fd_cnt; u0 = ur_cnt;
        send(0, 0);
        wait_frame("urun");
        check_frame("urun", 0, 0, 176);
        chk("urun_pulse_count", ur_cnt - u0, 1);
        chk("urun_no_frame_done", fd_cnt - f0, 0);
        chk("urun_pulse_at_de_fall", ur_cyc, fall_cyc);

        // padded instance
        sel = 1'b1;
        payload = {8'hAA};
        send(0, 1);
        wait_frame("pad");
        check_frame("pad", 60, 1, 1152);

        u0 = ur_cnt;
        for (int i = 0; i < 3; i++) begin
            fill(lens[i]);
            send(4, 1);
            wait_frame($sformatf("len%0d", lens[i]));
            check_frame($sformatf("len%0d", lens[i]), 60, 1, padded_len(lens[i]));
        end

        fill(20);
        send(0, 1);
        wait_frame("steady");
        check_frame("steady", 60, 1, padded_len(20));
        send(6, 1);
        wait_frame("jitter");
        check_frame("jitter", 60, 1, padded_len(20));
        chk("no_underrun_with_jitter", ur_cnt - u0, 0);

        back_to_back("b2b", 0);
        back_to_back("b2b_busy", 300);

        // reset in the middle of padding
        payload = {8'h11};
        send(0, 1);
        repeat (16 * 19) @(negedge clk);
        f0 = fd_cnt; u0 = ur_cnt;
        chk("pre_rst_de", de, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_de", de, 0);
        chk("rst_mid_ready", ready, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_ready_back", ready, 1);
        repeat (3) @(negedge clk);
        chk("rst_mid_no_frame_done", fd_cnt - f0, 0);
        chk("rst_mid_no_underrun", ur_cnt - u0, 0);
        fill(2);
        send(0, 1);
        wait_frame("post_rst");
        check_frame("post_rst", 60, 1, padded_len(2));

        chk("txd_stable_within_slot", glitches, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/enet_tx_mac.md
# enet_tx_mac

Transmit MAC sequencer for the 10BASE-T PLS transmitter. Accepts a frame as a byte stream from the host, then drives the PLS bit interface (`data_enable`, `txd_in`) at 10 Mb/s from `clk_20mhz`. The bit stream is preamble, SFD, payload, zero padding to minimum length, and CRC-32 FCS. Enforces the interframe gap and never starts a frame while the PLS reports busy.

## Interface
- `IFG_CYCLES`, 192: clocks of gap after the last FCS bit before a new frame may start (96 bit times).
- `MIN_PAYLOAD`, 60: minimum bytes (DA through payload) before FCS; short frames are zero-padded. 0 disables padding.
- `clk_20mhz`  in  1  system clock, 20 MHz.
- `rst_i`  in  1  reset. Synchronous, active-high.
- `tx_data`  in  8  host byte.
- `tx_valid`  in  1  `tx_data` and `tx_last` are valid.
- `tx_last`  in  1  this byte is the final payload byte of the frame.
- `tx_ready`  out  1  holding register empty. A byte transfers on `tx_valid & tx_ready`.
- `txbusy`  in  1  PLS busy, from the PLS `txbusy`.
- `data_enable`  out  1  to PLS `data_enable`. High continuously for the whole frame.
- `txd_out`  out  1  to PLS `txd_in`. Current NRZ bit.
- `frame_done`  out  1  one-cycle pulse when the last FCS bit slot ends.
- `tx_underrun`  out  1  one-cycle pulse when a frame is aborted for lack of data.

## Operation
- Bit slot: each bit is held on `txd_out` for exactly 2 clocks with `data_enable` high. Byte slot = 16 clocks. Bits are sent LSB first.
- State machine: IDLE → PREAMBLE → DATA → (PAD) → FCS → IFG → IDLE.
- IDLE
  - Start condition: `tx_valid` & `!txbusy`, evaluated after IFG has completed.
  - The first byte is accepted in the same cycle and goes into the holding register. `tx_ready` is high in IDLE.
- PREAMBLE: 7 bytes of 0x55, then SFD 0xD5 (64 bits). The CRC is not updated.
- DATA
  - At the end of each byte slot, the serializer loads from the holding register, which then becomes empty and raises `tx_ready`.
  - The holding register is empty at a load point and `tx_last` has not yet been transferred → underrun:
    - drop `data_enable` in the next cycle;
    - pulse `tx_underrun`;
    - go to IFG.
  - `tx_ready` stays low after the `tx_last` byte is accepted, until the next frame.
- PAD: when fewer than `MIN_PAYLOAD` bytes have been sent, send 0x00 bytes (CRC updated) until the count equals `MIN_PAYLOAD`. The byte counter is 11 bits and saturates at 2047.
- CRC
  - Serial CRC-32: reflected polynomial 0xEDB88320, init 0xFFFFFFFF.
  - Updated once per bit (on the first clock of each slot) over DATA and PAD bits.
  - FCS = bitwise NOT of the CRC register, shifted out LSB first for 32 bits.
- FCS: 32 bit slots. At the end of the last slot, pulse `frame_done` and drop `data_enable` in the next cycle.
- IFG: count `IFG_CYCLES`, then wait for `txbusy` low, then enter IDLE. `tx_valid` is ignored during IFG.
- `rst_i` mid-frame: the following all return to reset values in the next cycle, with no `frame_done` or `tx_underrun` pulse:
  - all state, counters and CRC;
  - `data_enable` (low);
  - the holding register (emptied).

## Timing
- Reset values: `data_enable`=0, `txd_out`=0, `tx_ready`=0 (rises the cycle after reset release), `frame_done`=0, `tx_underrun`=0, state IDLE, IFG satisfied.
- Start latency: the start condition is met in cycle T; `data_enable`=1 and `txd_out`=1 (first preamble bit) in cycle T+1.
- `data_enable` high time for an N-byte frame = 16·(8 + max(N, MIN_PAYLOAD) + 4) clocks, gap-free.
- `txd_out` is registered and changes only on even slot boundaries relative to T+1.
- A host byte offered at any point inside a slot is accepted without stalling the serializer. One byte of buffering.
- Earliest next start: `frame_done` cycle + 1 + `IFG_CYCLES`, and only once `txbusy`=0.

## Test plan
- **CRC check**
  - Stimulus: `MIN_PAYLOAD`=0; send ASCII "123456789" with `tx_last` on '9'.
  - Required: wire bits decode to 55×7, D5, 31..39, then FCS bytes 26 39 F4 CB; `data_enable` high exactly 16·21=336 clocks; one `frame_done`.
- **Padding**
  - Stimulus: default parameters; send one byte 0xAA.
  - Required: 1 + 59 zero bytes, then FCS; `data_enable` high 16·72=1152 clocks.
- **Underrun**
  - Stimulus: send 3 bytes without `tx_last`, then hold `tx_valid`=0.
  - Required: `tx_underrun` pulses at the 4th byte-slot load; `data_enable` falls the next cycle; no `frame_done`.
- **Back-to-back and IFG**
  - Stimulus: two frames queued with `tx_valid` held high; model `txbusy` per the PLS (high from the cycle after `data_enable` rises until 60 clocks after it falls).
  - Required: second `data_enable` rise is no earlier than `frame_done`+1+192 and no earlier than `txbusy` falling.
- **Reset mid-frame**
  - Stimulus: assert `rst_i` for 1 cycle during PAD.
  - Required: next cycle `data_enable`=0, `tx_ready`=0; following cycle `tx_ready`=1; new frame starts cleanly with init CRC.
- **Valid jitter**
  - Stimulus: toggle `tx_valid` randomly, but always present each byte before its slot load point.
  - Required: wire stream identical to the steady-valid case; no underrun.
